rs_encoder: RTL and testbench

//   Systematic Reed-Solomon encoder over GF(2^8), field poly x^8+x^7+x^2+x+1 (alpha=2).

---
 rtl/rs_encoder.sv | 138 +++++++++++++
 tb/tb_rs_encoder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/rs_encoder.sv
// Systematic RS(N,K) encoder over GF(2^8): K message symbols pass through, then N-K parity symbols.
// Latency 1 cycle; a single output register stalls the message input and the LFSR while m_valid & !m_ready.
module rs_encoder #(
  parameter int         N         = 255,
  parameter int         K         = 239,
  parameter int         GEN_START = 0,
  parameter logic [8:0] PRIM_POLY = 9'h187
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [7:0] m_data,
  output logic       m_parity,
  output logic       m_last
);

  localparam int NPAR = N - K;
  localparam int CW   = $clog2(N);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? PRIM_POLY[7:0] : 8'h00);
    end
    return p;
  endfunction

  // Coefficients g[0..NPAR-1] of the monic generator; g[NPAR]=1 is implicit.
  function automatic logic [8*NPAR-1:0] gen_poly();
    logic [8*(NPAR+1)-1:0] g;
    logic [7:0]            root;
    g       = '0;
    g[7:0]  = 8'h01;
    root    = 8'h01;
    for (int e = 0; e < GEN_START; e++) root = gf_mul(root, 8'h02);
    for (int j = 0; j < NPAR; j++) begin
      for (int i = j + 1; i >= 1; i--)
        g[8*i +: 8] = g[8*(i-1) +: 8] ^ gf_mul(root, g[8*i +: 8]);
      g[7:0] = gf_mul(root, g[7:0]);
      root   = gf_mul(root, 8'h02);
    end
    return g[8*NPAR-1:0];
  endfunction

  localparam logic [8*NPAR-1:0] G = gen_poly();

  typedef enum logic {ST_MSG, ST_PAR} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_m_valid;
  logic [7:0]      r_m_data;
  logic            r_m_parity;
  logic            r_m_last;
  logic [CW-1:0]   r_sym_cnt;
  logic [7:0]      r_lfsr [NPAR];
  logic [7:0]      w_lfsr_msg [NPAR];
  logic [7:0]      w_fb;
  logic            w_out_free;
  logic            w_msg_acc;
  logic            w_par_ld;
  logic            w_msg_end;
  logic            w_par_end;

  assign w_out_free = !r_m_valid | m_ready;
  assign w_msg_end  = (r_sym_cnt == CW'(K - 1));
  assign w_par_end  = (r_sym_cnt == CW'(NPAR - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_MSG;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_MSG:  if (w_msg_acc && w_msg_end) w_state_nxt = ST_PAR;
      ST_PAR:  if (w_par_ld && w_par_end)  w_state_nxt = ST_MSG;
      default: w_state_nxt = ST_MSG;
    endcase
  end

  always_comb begin
    s_ready   = (r_state == ST_MSG) & w_out_free;
    w_msg_acc = s_valid & s_ready;
    w_par_ld  = (r_state == ST_PAR) & w_out_free;
  end

  always_comb begin
    w_fb          = s_data ^ r_lfsr[NPAR-1];
    w_lfsr_msg[0] = gf_mul(w_fb, G[7:0]);
    for (int i = 1; i < NPAR; i++)
      w_lfsr_msg[i] = r_lfsr[i-1] ^ gf_mul(w_fb, G[8*i +: 8]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_m_valid  <= 1'b0;
      r_m_data   <= 8'h00;
      r_m_parity <= 1'b0;
      r_m_last   <= 1'b0;
      r_sym_cnt  <= '0;
      for (int i = 0; i < NPAR; i++) r_lfsr[i] <= 8'h00;
    end else if (w_msg_acc) begin
      r_m_data   <= s_data;
      r_m_valid  <= 1'b1;
      r_m_parity <= 1'b0;
      r_m_last   <= 1'b0;
      r_sym_cnt  <= w_msg_end ? '0 : r_sym_cnt + CW'(1);
      for (int i = 0; i < NPAR; i++) r_lfsr[i] <= w_lfsr_msg[i];
    end else if (w_par_ld) begin
      r_m_data   <= r_lfsr[NPAR-1];
      r_m_valid  <= 1'b1;
      r_m_parity <= 1'b1;
      r_m_last   <= w_par_end;
      r_sym_cnt  <= w_par_end ? '0 : r_sym_cnt + CW'(1);
      // Shifting with zero feedback drains the remainder; clear explicitly at frame end.
      r_lfsr[0]  <= 8'h00;
      for (int i = 1; i < NPAR; i++) r_lfsr[i] <= w_par_end ? 8'h00 : r_lfsr[i-1];
    end else if (w_out_free) begin
      r_m_valid  <= 1'b0;
    end
  end

  assign m_valid  = r_m_valid;
  assign m_data   = r_m_data;
  assign m_parity = r_m_parity;
  assign m_last   = r_m_last;

endmodule

// File: tb/tb_rs_encoder.sv
// Bench for rs_encoder: log/antilog GF model, polynomial long division reference, syndrome checks.
module tb_rs_encoder;
  localparam int N    = 255;
  localparam int K    = 239;
  localparam int NPAR = N - K;
  localparam int GS   = 0;
  localparam int MAXF = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] s_data = 8'h00;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic [7:0] m_data;
  logic       m_parity;
  logic       m_last;

  always #5 clk = ~clk;

  rs_encoder #(.N(N), .K(K), .GEN_START(GS), .PRIM_POLY(9'h187)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_parity(m_parity), .m_last(m_last)
  );

  int checks = 0;
  int errors = 0;
  int gexp [0:254];
  int glog [0:255];
  int gen  [0:NPAR];
  int msg  [0:MAXF*K-1];
  int od   [0:MAXF*N-1];
  int op   [0:MAXF*N-1];
  int ol   [0:MAXF*N-1];
  int cw   [0:N-1];
  int ref3 [0:N-1];
  int nout, stall_bad, gaps;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int gmul(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return gexp[(glog[a] + glog[b]) % 255];
  endfunction

  task automatic build_model();
    int x;
    int tmp [0:NPAR];
    x = 1;
    for (int i = 0; i < 255; i++) begin
      gexp[i] = x;
      glog[x] = i;
      x = x << 1;
      if (x >= 256) x = x ^ 'h187;
    end
    for (int i = 0; i <= NPAR; i++) gen[i] = (i == 0) ? 1 : 0;
    for (int j = 0; j < NPAR; j++) begin
      int r;
      r = gexp[(GS + j) % 255];
      for (int i = 0; i <= NPAR; i++) tmp[i] = ((i > 0) ? gen[i-1] : 0) ^ gmul(r, gen[i]);
      for (int i = 0; i <= NPAR; i++) gen[i] = tmp[i];
    end
  endtask

  // Codeword of frame f by long division of m(x)*x^NPAR by g(x).
  task automatic golden(input int f);
    int d [0:N-1];
    for (int i = 0; i < N; i++) d[i] = 0;
    for (int i = 0; i < K; i++) d[N-1-i] = msg[f*K + i];
    for (int deg = N - 1; deg >= NPAR; deg--) begin
      int c;
      c = d[deg];
      if (c != 0)
        for (int j = 0; j <= NPAR; j++) d[deg-NPAR+j] = d[deg-NPAR+j] ^ gmul(c, gen[j]);
    end
    for (int i = 0; i < K; i++) cw[i] = msg[f*K + i];
    for (int i = 0; i < NPAR; i++) cw[K+i] = d[NPAR-1-i];
  endtask

  function automatic int syn(input int f, input int j);
    int s, r;
    r = gexp[(GS + j) % 255];
    s = 0;
    for (int i = 0; i < N; i++) s = gmul(s, r) ^ od[f*N + i];
    return s;
  endfunction

  task automatic compare_frame(input int f, input string tag);
    int md, mp, ml;
    golden(f);
    md = 0; mp = 0; ml = 0;
    for (int i = 0; i < N; i++) begin
      if (od[f*N+i] != cw[i]) md++;
      if (op[f*N+i] != ((i >= K) ? 1 : 0)) mp++;
      if (ol[f*N+i] != ((i == N - 1) ? 1 : 0)) ml++;
    end
    check({tag, "_data_mism"}, md, 0);
    check({tag, "_parity_flag_mism"}, mp, 0);
    check({tag, "_last_flag_mism"}, ml, 0);
  endtask

  // Streams nf frames from msg[], collecting every output handshake.
  task automatic run(input int nf, input int vpct, input int rpct);
    int in_idx, cyc, held, held_dat, held_par, seen;
    in_idx = 0; cyc = 0; held = 0; held_dat = 0; held_par = 0; seen = 0;
    nout = 0; stall_bad = 0; gaps = 0;
    while (nout < nf * N && cyc < nf * 4000) begin
      @(negedge clk);
      if (held != 0 && !(m_valid === 1'b1 && int'(m_data) == held_dat && int'(m_parity) == held_par))
        stall_bad++;
      s_valid = (in_idx < nf * K) && ($urandom_range(99, 0) < vpct);
      s_data  = s_valid ? 8'(msg[in_idx]) : 8'($urandom);
      m_ready = ($urandom_range(99, 0) < rpct);
      #1;
      if (s_valid && s_ready) in_idx++;
      if (m_valid) seen = 1;
      else if (seen != 0) gaps++;
      if (m_valid && m_ready) begin
        od[nout] = int'(m_data);
        op[nout] = int'(m_parity);
        ol[nout] = int'(m_last);
        nout++;
      end
      held     = (m_valid && !m_ready) ? 1 : 0;
      held_dat = int'(m_data);
      held_par = int'(m_parity);
      cyc++;
    end
    check("frame_output_count", nout, nf * N);
  endtask

  initial begin
    build_model();

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_m_valid", int'(m_valid), 0);
    check("rst_m_data", int'(m_data), 0);
    check("rst_m_parity", int'(m_parity), 0);
    check("rst_m_last", int'(m_last), 0);
    rst = 1'b0;
    #1;
    check("idle_s_ready", int'(s_ready), 1);

    // All-zero message
    for (int i = 0; i < K; i++) msg[i] = 0;
    run(1, 100, 100);
    compare_frame(0, "zero");

    // Single 0x01 in lowest message position: parity is g(x) without its leading term
    for (int i = 0; i < K; i++) msg[i] = (i == K - 1) ? 1 : 0;
    run(1, 100, 100);
    for (int i = 0; i < NPAR; i++)
      check($sformatf("unit_parity_%0d", i), od[K+i], gen[NPAR-1-i]);

    // Random message, full rate
    for (int i = 0; i < K; i++) msg[i] = int'($urandom_range(255, 0));
    run(1, 100, 100);
    compare_frame(0, "rand");
    for (int j = 0; j < NPAR; j++) check($sformatf("rand_syndrome_%0d", j), syn(0, j), 0);
    for (int i = 0; i < N; i++) ref3[i] = od[i];

    // Same message under random backpressure and input gaps
    run(1, 60, 50);
    begin
      int md;
      md = 0;
      for (int i = 0; i < N; i++) if (od[i] != ref3[i]) md++;
      check("stall_vs_fullrate_mism", md, 0);
    end
    check("stall_hold_violations", stall_bad, 0);
    compare_frame(0, "stall");

    // Reset in the middle of a frame
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = 8'($urandom);
      m_ready = 1'b1;
    end
    @(negedge clk);
    s_valid = 1'b0;
    check("pre_rst_m_valid", int'(m_valid), 1);
    rst = 1'b1;
    @(negedge clk);
    check("midframe_rst_m_valid", int'(m_valid), 0);
    check("midframe_rst_m_parity", int'(m_parity), 0);
    rst = 1'b0;
    for (int i = 0; i < K; i++) msg[i] = int'($urandom_range(255, 0));
    run(1, 100, 100);
    compare_frame(0, "post_rst");
    check("post_rst_syndrome_0", syn(0, 0), 0);
    check("post_rst_syndrome_15", syn(0, NPAR - 1), 0);

    // Three frames back to back
    for (int i = 0; i < MAXF * K; i++) msg[i] = int'($urandom_range(255, 0));
    run(MAXF, 100, 100);
    check("b2b_valid_gaps", gaps, 0);
    for (int f = 0; f < MAXF; f++) begin
      compare_frame(f, $sformatf("b2b_f%0d", f));
      check($sformatf("b2b_f%0d_syndrome_7", f), syn(f, 7), 0);
    end

    @(negedge clk);
    s_valid = 1'b0;
    m_ready = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
